// File: rtl/path_walker.sv
// Hypercube path walker: loads a list of dimension indices plus a source node and
// emits one hop (dimension, resulting node, index, last flag) per accepted handshake.
module path_walker #(
  parameter int unsigned DIM      = 4,
  parameter int unsigned MAX_HOPS = 16,
  parameter int unsigned DW       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [DIM-1:0]         src_node,
  input  logic [4:0]             hop_cnt,
  input  logic [MAX_HOPS*DW-1:0] path_i,
  input  logic                   abort,
  output logic                   hop_valid,
  input  logic                   hop_ready,
  output logic [DW-1:0]          hop_dim,
  output logic [DIM-1:0]         hop_node,
  output logic [3:0]             hop_idx,
  output logic                   hop_last,
  output logic                   done,
  output logic [DIM-1:0]         final_node,
  output logic                   err
);

  localparam int unsigned CW = 5;
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                 state;
  logic [MAX_HOPS*DW-1:0] path_r;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;

  logic [IW-1:0]          nxt_idx;
  logic [DW-1:0]          nxt_dim;
  logic                   nxt_last;
  logic [DW-1:0]          first_dim;

  // One-hot flip mask; dimension indices >= DIM flip nothing.
  function automatic logic [DIM-1:0] flip_mask(input logic [DW-1:0] d);
    logic [DIM-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      if (i == int'(d)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] entry(input logic [MAX_HOPS*DW-1:0] p,
                                          input logic [IW-1:0] k);
    return p[DW*int'(k) +: DW];
  endfunction

  // Lookahead for the hop presented after the current one is accepted.
  always_comb begin
    nxt_idx   = idx + IW'(1);
    nxt_dim   = entry(path_r, nxt_idx);
    nxt_last  = (CW'(nxt_idx) == (cnt - CW'(1)));
    first_dim = entry(path_i, IW'(0));
  end

  // hop_node doubles as the current node: it always holds the address after the
  // presented hop, which becomes the current node once that hop is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      path_r     <= '0;
      idx        <= '0;
      cnt        <= '0;
      load_ready <= 1'b1;
      hop_valid  <= 1'b0;
      hop_dim    <= '0;
      hop_node   <= '0;
      hop_idx    <= '0;
      hop_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      final_node <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        load_ready <= 1'b1;
        hop_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              if (hop_cnt > CW'(MAX_HOPS)) begin
                err <= 1'b1;
              end else if (hop_cnt == '0) begin
                state      <= DONE;
                load_ready <= 1'b0;
                done       <= 1'b1;
                hop_node   <= src_node;
                final_node <= src_node;
              end else begin
                state      <= WALK;
                load_ready <= 1'b0;
                path_r     <= path_i;
                idx        <= '0;
                cnt        <= hop_cnt;
                hop_valid  <= 1'b1;
                hop_dim    <= first_dim;
                hop_node   <= src_node ^ flip_mask(first_dim);
                hop_idx    <= '0;
                hop_last   <= (hop_cnt == CW'(1));
              end
            end
          end
          WALK: begin
            if (hop_valid && hop_ready) begin
              if (hop_last) begin
                state      <= DONE;
                hop_valid  <= 1'b0;
                hop_last   <= 1'b0;
                done       <= 1'b1;
                final_node <= hop_node;
              end else begin
                idx      <= nxt_idx;
                hop_idx  <= nxt_idx;
                hop_dim  <= nxt_dim;
                hop_node <= hop_node ^ flip_mask(nxt_dim);
                hop_last <= nxt_last;
              end
            end
          end
          DONE: begin
            state      <= IDLE;
            load_ready <= 1'b1;
          end
          default: begin
            state      <= IDLE;
            load_ready <= 1'b1;
            hop_valid  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_path_walker.sv
// Scoreboard bench for path_walker: expected hops are queued at load time and
// popped as the walker presents them; done timing and final node checked per walk.
module tb_path_walker;

  localparam int unsigned DIM = 4;
  localparam int unsigned MAX_HOPS = 16;
  localparam int unsigned DW = 2;

  typedef struct packed {
    logic [1:0] dim;
    logic [3:0] node;
    logic [3:0] idx;
    logic       last;
  } hop_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  src_node = '0;
  logic [4:0]  hop_cnt = '0;
  logic [31:0] path_i = '0;
  logic        abort = 1'b0;
  logic        hop_valid;
  logic        hop_ready = 1'b0;
  logic [1:0]  hop_dim;
  logic [3:0]  hop_node;
  logic [3:0]  hop_idx;
  logic        hop_last;
  logic        done;
  logic [3:0]  final_node;
  logic        err;

  int vecs = 0;
  int miscompares = 0;
  hop_t exp_q[$];
  logic [31:0] path_a;
  logic [31:0] path_b;
  logic [31:0] path_c;

  path_walker #(.DIM(DIM), .MAX_HOPS(MAX_HOPS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .src_node(src_node), .hop_cnt(hop_cnt), .path_i(path_i), .abort(abort),
    .hop_valid(hop_valid), .hop_ready(hop_ready), .hop_dim(hop_dim),
    .hop_node(hop_node), .hop_idx(hop_idx), .hop_last(hop_last), .done(done),
    .final_node(final_node), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack_path(input int d[16]);
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < 16; k++) p[2*k +: 2] = 2'(d[k]);
    return p;
  endfunction

  // Called at a negedge: present one list for one cycle and queue its expected hops.
  task automatic load(input logic [3:0] src, input logic [4:0] cnt, input logic [31:0] p);
    logic [3:0] node;
    logic [1:0] d;
    vecs++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_ready_before_load: got %b want 1", load_ready);
    end
    node = src;
    if (cnt <= 5'd16) begin
      for (int k = 0; k < int'(cnt); k++) begin
        d = p[2*k +: 2];
        node = node ^ (4'b0001 << d);
        exp_q.push_back('{dim: d, node: node, idx: 4'(k), last: (k == int'(cnt) - 1)});
      end
    end
    load_valid = 1'b1; src_node = src; hop_cnt = cnt; path_i = p;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Runs a walk from the negedge right after load accept (cycle 1).
  task automatic walk(input int stall_idx, input int stall_n, input int abort_idx,
                      input int exp_done, input logic [3:0] exp_final);
    int stalls;
    bit seen_done;
    bit aborted;
    hop_t e;
    stalls = stall_n;
    seen_done = 0;
    aborted = 0;
    for (int c = 1; c < 200 && !seen_done && !aborted; c++) begin
      hop_ready = 1'b0;
      abort = 1'b0;
      if (hop_valid) begin
        vecs++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_hop: got idx=%0d node=%0d, none expected", hop_idx, hop_node);
        end else begin
          e = exp_q[0];
          if ({hop_dim, hop_node, hop_idx, hop_last} !== e) begin
            miscompares++;
            $display("FAIL hop: got dim=%0d node=%0d idx=%0d last=%b want dim=%0d node=%0d idx=%0d last=%b",
                     hop_dim, hop_node, hop_idx, hop_last, e.dim, e.node, e.idx, e.last);
          end
          if (int'(hop_idx) == abort_idx) begin
            abort = 1'b1;
          end else if (int'(hop_idx) == stall_idx && stalls > 0) begin
            stalls--;
          end else begin
            hop_ready = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        seen_done = 1;
        vecs++;
        if (c != exp_done || final_node !== exp_final || exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL done: got cycle=%0d final=%0d left=%0d want cycle=%0d final=%0d left=0",
                   c, final_node, exp_q.size(), exp_done, exp_final);
        end
      end
      if (abort) aborted = 1;
      @(negedge clk);
    end
    hop_ready = 1'b0;
    abort = 1'b0;
    if (aborted) begin
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (hop_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL after_abort: got valid=%b done=%b ready=%b want 0 0 1",
                   hop_valid, done, load_ready);
        end
        @(negedge clk);
      end
    end else begin
      vecs++;
      if (!seen_done) begin
        miscompares++;
        $display("FAIL done_timeout: got no done want done at cycle %0d", exp_done);
      end else if (load_ready !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL after_done: got ready=%b done=%b want 1 0", load_ready, done);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    vecs++;
    if ({load_ready, hop_valid, done, err, hop_node, final_node, hop_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL %s: got ready=%b valid=%b done=%b err=%b node=%0d final=%0d idx=%0d want 1 0 0 0 0 0 0",
               tag, load_ready, hop_valid, done, err, hop_node, final_node, hop_idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_release");
  endtask

  task automatic test_full_walk();
    load(4'd0, 5'd16, path_a);
    walk(-1, 0, -1, 17, 4'd0);
  endtask

  task automatic test_stall();
    load(4'd0, 5'd16, path_a);
    walk(2, 3, -1, 20, 4'd0);
  endtask

  task automatic test_cnt_zero();
    load(4'd5, 5'd0, path_a);
    walk(-1, 0, -1, 1, 4'd5);
  endtask

  task automatic test_err();
    load(4'd3, 5'd17, path_a);
    vecs++;
    if (err !== 1'b1 || hop_valid !== 1'b0 || load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL err_pulse: got err=%b valid=%b ready=%b want 1 0 1", err, hop_valid, load_ready);
    end
    @(negedge clk);
    vecs++;
    if (err !== 1'b0 || hop_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b valid=%b done=%b want 0 0 0", err, hop_valid, done);
    end
    load(4'd9, 5'd3, path_b);
    walk(-1, 0, -1, 4, 4'd2);
  endtask

  task automatic test_abort();
    load(4'd0, 5'd16, path_a);
    walk(-1, 0, 5, 0, 4'd0);
    load(4'd15, 5'd2, path_c);
    walk(-1, 0, -1, 3, 4'd15);
  endtask

  task automatic test_reset_mid_walk();
    load(4'd0, 5'd16, path_a);
    hop_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    hop_ready = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("post_reset_idle");
    end
  endtask

  initial begin
    int pa[16];
    int pb[16];
    int pc[16];
    pa = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};
    pb = '{3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pc = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    path_a = pack_path(pa);
    path_b = pack_path(pb);
    path_c = pack_path(pc);
    test_reset();
    test_full_walk();
    test_stall();
    test_cnt_zero();
    test_err();
    test_abort();
    test_reset_mid_walk();
    test_full_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
